// File: rtl/button_repeat_ctrl.sv
// Synchronises, debounces and arbitrates the two servo pushbuttons into one-cycle inc/dec pulses.
// Build with AUTOREPEAT_EN defined for hold-to-repeat; otherwise one pulse per press.
module button_repeat_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 10_000,
    parameter int unsigned REPEAT_DELAY    = 5_000_000,
    parameter int unsigned REPEAT_PERIOD   = 1_000_000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_inc,
    input  logic pb_dec,
    output logic inc_pulse,
    output logic dec_pulse,
    output logic busy
);

    localparam int unsigned CW           = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [1:0]  RELEASED_LVL = {2{ACTIVE_LOW}};

    // Elaboration-time parameter sanity checks
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_DELAY < 2) begin : g_bad_delay
        $error("REPEAT_DELAY must be at least 2");
    end
    if (REPEAT_PERIOD < 2) begin : g_bad_period
        $error("REPEAT_PERIOD must be at least 2");
    end

`ifdef AUTOREPEAT_EN
    localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT,
        ST_LOCKOUT
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HELD,
        ST_LOCKOUT
    } state_e;
`endif

    // Bit 0 is the increment button, bit 1 the decrement button throughout.
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    press_c;
    logic [1:0]    deb_q;
    logic [1:0]    deb_d;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];

    state_e        state_q;
    state_e        state_d;
    logic          dir_q;
    logic          dir_d;
    logic          fire_c;
    logic          own_c;
    logic          other_c;
`ifdef AUTOREPEAT_EN
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
`endif

    logic          inc_pulse_q;
    logic          inc_pulse_d;
    logic          dec_pulse_q;
    logic          dec_pulse_d;
    logic          busy_q;
    logic          busy_d;

    // Two-flop synchroniser, reset to the released level so a held button re-qualifies
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= RELEASED_LVL;
            sync2_q <= RELEASED_LVL;
        end else begin
            sync1_q <= {pb_dec, pb_inc};
            sync2_q <= sync1_q;
        end
    end

    assign press_c = sync2_q ^ RELEASED_LVL;

    // Debouncer: level flips only after DEBOUNCE_CYCLES consecutive differing samples
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (press_c[i] != deb_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_q    <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            deb_q    <= deb_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
        end
    end

    assign own_c   = dir_q ? deb_q[1] : deb_q[0];
    assign other_c = dir_q ? deb_q[0] : deb_q[1];

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            dir_q       <= 1'b0;
`ifdef AUTOREPEAT_EN
            timer_q     <= '0;
`endif
            inc_pulse_q <= 1'b0;
            dec_pulse_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
`ifdef AUTOREPEAT_EN
            timer_q     <= timer_d;
`endif
            inc_pulse_q <= inc_pulse_d;
            dec_pulse_q <= dec_pulse_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic; lockout and release take priority over a due pulse
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        fire_c  = 1'b0;
`ifdef AUTOREPEAT_EN
        timer_d = (timer_q != '0) ? timer_q - TW'(1) : '0;
        case (state_q)
            ST_IDLE: begin
                if (deb_q == 2'b11) begin
                    state_d = ST_LOCKOUT;
                    timer_d = '0;
                end else if (deb_q != 2'b00) begin
                    fire_c  = 1'b1;
                    dir_d   = deb_q[1];
                    state_d = ST_DELAY;
                    timer_d = TW'(REPEAT_DELAY - 1);
                end
            end
            ST_DELAY, ST_REPEAT: begin
                if (other_c) begin
                    state_d = ST_LOCKOUT;
                    timer_d = '0;
                end else if (!own_c) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (timer_q == '0) begin
                    fire_c  = 1'b1;
                    state_d = ST_REPEAT;
                    timer_d = TW'(REPEAT_PERIOD - 1);
                end
            end
            ST_LOCKOUT: begin
                if (deb_q == 2'b00) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
`else
        case (state_q)
            ST_IDLE: begin
                if (deb_q == 2'b11) begin
                    state_d = ST_LOCKOUT;
                end else if (deb_q != 2'b00) begin
                    fire_c  = 1'b1;
                    dir_d   = deb_q[1];
                    state_d = ST_HELD;
                end
            end
            ST_HELD: begin
                if (other_c) begin
                    state_d = ST_LOCKOUT;
                end else if (!own_c) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                if (deb_q == 2'b00) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`endif
    end

    // Output decode; a single fire plus a direction bit keeps inc/dec exclusive
    always_comb begin
        busy_d      = (state_d != ST_IDLE);
        inc_pulse_d = fire_c & ~dir_d;
        dec_pulse_d = fire_c & dir_d;
    end

    assign inc_pulse = inc_pulse_q;
    assign dec_pulse = dec_pulse_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_button_repeat_ctrl.sv
// Self-checking bench for button_repeat_ctrl: vector table plus hand-written corner sequences,
// with expected pulses queued on a scoreboard as stimulus is driven.
module tb_button_repeat_ctrl;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;
    localparam int LAT = DEB + 3;
`ifdef AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic pb_inc;
    logic pb_dec;
    logic inc_pulse;
    logic dec_pulse;
    logic busy;

    always #5 clk = ~clk;

    button_repeat_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pb_inc   (pb_inc),
        .pb_dec   (pb_dec),
        .inc_pulse(inc_pulse),
        .dec_pulse(dec_pulse),
        .busy     (busy)
    );

    typedef struct {
        int cyc;
        bit is_dec;
    } exp_t;

    typedef struct {
        string name;
        bit    use_dec;
        int    on;
        int    off;
        int    run;
        int    n_exp;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[8];
    int   n_vec     = 0;
    int   n_err     = 0;
    int   cyc       = 0;
    int   pulse_cnt = 0;
    int   busy_cnt  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Advance one clock, sample #1 after the edge and match any pulse against the scoreboard
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (busy) busy_cnt++;
        if (inc_pulse || dec_pulse) begin
            pulse_cnt++;
            check("pulse_exclusive", int'(inc_pulse) + int'(dec_pulse), 1);
            if (sb.size() == 0) begin
                check("unexpected_pulse_at_cycle", cyc, -1);
            end else begin
                e = sb.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_is_dec", int'(dec_pulse), int'(e.is_dec));
            end
        end
    endtask

    task automatic drain(input string name);
        exp_t e;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            check({name, "_missing_pulse_cycle"}, -1, e.cyc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit press;
        int r;

        rst    = 1'b0;
        pb_inc = 1'b1;
        pb_dec = 1'b1;

        //         name           dec   on  off  run  expected pulses
        tbl[0] = '{"inc_10",      1'b0, 2,  12,  30,  1};
        tbl[1] = '{"dec_60",      1'b1, 2,  62,  80,  AR ? 6 : 1};
        tbl[2] = '{"inc_100",     1'b0, 2,  102, 120, AR ? 11 : 1};
        tbl[3] = '{"dec_min_4",   1'b1, 2,  6,   20,  1};
        tbl[4] = '{"inc_short_3", 1'b0, 2,  5,   20,  0};
        tbl[5] = '{"dec_20",      1'b1, 2,  22,  40,  1};
        tbl[6] = '{"dec_21",      1'b1, 2,  23,  40,  AR ? 2 : 1};
        tbl[7] = '{"inc_28",      1'b0, 5,  33,  50,  AR ? 2 : 1};

        // Reset state, then 100 idle cycles with both buttons released
        repeat (3) @(posedge clk);
        #1;
        check("rst_inc_pulse", int'(inc_pulse), 0);
        check("rst_dec_pulse", int'(dec_pulse), 0);
        check("rst_busy", int'(busy), 0);
        rst      = 1'b1;
        cyc      = 0;
        busy_cnt = 0;
        repeat (100) step();
        check("idle_busy_cycles", busy_cnt, 0);
        check("idle_pulses", pulse_cnt, 0);

        // Single-button presses: first pulse at on+LAT, repeats at +RD then every RP
        for (int v = 0; v < 8; v++) begin
            cyc = 0;
            for (int k = 0; k < tbl[v].n_exp; k++) begin
                sb.push_back('{cyc: (k == 0) ? tbl[v].on + LAT
                                             : tbl[v].on + LAT + RD + (k - 1) * RP,
                               is_dec: tbl[v].use_dec});
            end
            while (cyc < tbl[v].run) begin
                press  = (cyc >= tbl[v].on) && (cyc < tbl[v].off);
                pb_inc = ~(press & ~tbl[v].use_dec);
                pb_dec = ~(press & tbl[v].use_dec);
                step();
                if (cyc == tbl[v].on + LAT)
                    check({tbl[v].name, "_busy_after_press"}, int'(busy), int'(tbl[v].n_exp > 0));
                if (cyc == tbl[v].off + LAT - 1)
                    check({tbl[v].name, "_busy_before_release"}, int'(busy), int'(tbl[v].n_exp > 0));
                if (cyc == tbl[v].off + LAT)
                    check({tbl[v].name, "_busy_after_release"}, int'(busy), 0);
            end
            drain(tbl[v].name);
        end

        // Bounce: 3-low/3-high bursts never qualify
        cyc       = 0;
        pulse_cnt = 0;
        busy_cnt  = 0;
        for (int b = 0; b < 10; b++) begin
            pb_inc = 1'b0;
            repeat (3) step();
            pb_inc = 1'b1;
            repeat (3) step();
        end
        repeat (10) step();
        check("burst_pulses", pulse_cnt, 0);
        check("burst_busy_cycles", busy_cnt, 0);

        // Simultaneous press locks out until both are released
        cyc       = 0;
        pulse_cnt = 0;
        while (cyc < 60) begin
            press  = (cyc >= 2) && (cyc < 42);
            pb_inc = ~press;
            pb_dec = ~press;
            step();
            if (cyc == 8)  check("both_busy_pre", int'(busy), 0);
            if (cyc == 9)  check("both_busy_lockout", int'(busy), 1);
            if (cyc == 48) check("both_busy_held", int'(busy), 1);
            if (cyc == 49) check("both_busy_idle", int'(busy), 0);
        end
        check("both_pulses", pulse_cnt, 0);

        // Reset mid-hold: outputs clear at once, held button re-qualifies afterwards
        cyc = 0;
        sb.push_back('{cyc: 2 + LAT, is_dec: 1'b0});
        while (cyc < 15) begin
            pb_inc = (cyc < 2);
            step();
        end
        check("midrst_busy_before", int'(busy), 1);
        rst = 1'b0;
        #1;
        check("midrst_busy_async", int'(busy), 0);
        check("midrst_inc_async", int'(inc_pulse), 0);
        check("midrst_dec_async", int'(dec_pulse), 0);
        repeat (3) step();
        rst = 1'b1;
        r   = cyc;
        sb.push_back('{cyc: r + LAT, is_dec: 1'b0});
        while (cyc < r + 25) begin
            pb_inc = (cyc >= r + 10);
            step();
            if (cyc == r + LAT - 1) check("midrst_busy_requal", int'(busy), 0);
            if (cyc == r + LAT)     check("midrst_busy_pulse", int'(busy), 1);
            if (cyc == r + 17)      check("midrst_busy_release", int'(busy), 0);
        end
        drain("midrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
